multi_cycle_adder: RTL and testbench
====================================

MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle; legal values 1..WIDTH with WIDTH % CHUNK == 0.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands A, B and Cin are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port A  input  WIDTH  first operand.
REQ-008 SHALL have port B  input  WIDTH  second operand.
REQ-009 SHALL have port Cin  input  1  carry-in to bit 0.
REQ-010 SHALL have port out_valid  output  1  F and Carry hold a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port F  output  WIDTH  sum.
REQ-013 SHALL have port Carry  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port busy  output  1  high while in state ADD.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 SHALL accept operands on any edge where in_valid && in_ready: register A, B and Cin; clear the chunk index to 0; go to ADD.
REQ-018 SHALL ignore changes on A, B and Cin after acceptance until the next acceptance.
REQ-019 In ADD, each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of the captured A and B plus the registered carry, write the sum into F chunk k, update the carry register, and increment k.
REQ-020 The first ADD cycle SHALL use the captured Cin as carry-in.
REQ-021 After chunk N-1 (N = WIDTH/CHUNK), SHALL go to DONE with Carry = final carry; ADD lasts exactly N cycles.
REQ-022 SHALL raise out_valid exactly N cycles after the acceptance edge and hold it high in DONE only.
REQ-023 In DONE, SHALL hold F, Carry and out_valid stable until out_ready is high, then return to IDLE on that edge.
REQ-024 When out_valid && out_ready, in_ready SHALL stay low that cycle; the next accept SHALL occur no earlier than the following edge.
REQ-025 SHALL produce F + Carry*2^WIDTH == A + B + Cin, modulo 2^(WIDTH+1).
REQ-026 With CHUNK == WIDTH, SHALL complete in one ADD cycle.
REQ-027 SHALL ignore in_valid while in ADD or DONE; no operand is queued.

Reset
REQ-028 When rst_n is low at a rising clk edge, SHALL go to IDLE and clear F, Carry, out_valid, busy, the chunk index, the carry register and the operand registers to 0.
REQ-029 Reset asserted in ADD or DONE SHALL abandon the operation with no output; in_ready SHALL be high on the first cycle after rst_n returns high.

Configuration
REQ-030 Macro MULTI_CYCLE_ADDER_SUB_EN: when defined, SHALL add port Sub (input, 1), captured at acceptance; Sub=1 computes A + ~B + 1 (Cin ignored, Carry = no-borrow); Sub=0 matches REQ-025.
REQ-031 Without MULTI_CYCLE_ADDER_SUB_EN, SHALL have no Sub port and perform addition only.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 A=0x00FF, B=0x0001, Cin=0, out_ready=1 -> busy high 4 cycles; out_valid 4 cycles after accept; F=0x0100, Carry=0.
REQ-033 A=0xFFFF, B=0x0001, Cin=0 -> F=0x0000, Carry=1; A=0x1234, B=0x4321, Cin=1 -> F=0x5556, Carry=0.
REQ-034 out_ready=0 for 5 cycles after out_valid, A/B/in_valid toggling -> F, Carry and out_valid stable, in_ready low; out_ready=1 -> IDLE next edge.
REQ-035 rst_n low for 1 cycle during the 2nd ADD cycle -> all outputs 0, out_valid never asserted, in_ready=1 after release; next op 0x0003+0x0004 -> F=0x0007.
REQ-036 SUB_EN defined, A=0x0005, B=0x0007, Sub=1 -> F=0xFFFE, Carry=0; A=0x0007, B=0x0005 -> F=0x0002, Carry=1.
REQ-037 WIDTH=8, CHUNK=8 and CHUNK=1: A=0xF0, B=0x10 -> F=0x00, Carry=1, latency 1 and 8 cycles respectively.

Source files
------------

// File: rtl/multi_cycle_adder.sv
`timescale 1ns/1ps
// multi_cycle_adder: adds two WIDTH-bit operands CHUNK bits per clock,
// rippling the carry through a register between chunks.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (A, B, Cin; Sub when enabled)
//   out_valid / out_ready result handshake (F, Carry)
//   busy                  high while chunks are being added
//
// Optional feature: define MULTI_CYCLE_ADDER_SUB_EN to add input Sub,
// which selects A + ~B + 1 (Carry then means no-borrow).
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             Carry,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cy;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_f;
    logic             r_carry;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cy_in;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Subtraction is folded into capture: store ~B and force carry-in.
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    assign w_b_in  = Sub ? ~B : B;
    assign w_cy_in = Sub ? 1'b1 : Cin;
`else
    assign w_b_in  = B;
    assign w_cy_in = Cin;
`endif

    assign w_last    = (r_k == K_LAST);
    assign w_a_chunk = r_a[int'(r_k)*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[int'(r_k)*CHUNK +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk}
                     + {1'b0, w_b_chunk}
                     + {{CHUNK{1'b0}}, r_cy};

    // Datapath: capture operands, then one chunk per ADD cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cy    <= 1'b0;
            r_k     <= '0;
            r_f     <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= w_b_in;
            r_cy    <= w_cy_in;
            r_k     <= '0;
            r_f     <= '0;
            r_carry <= 1'b0;
        end else if (r_state == S_ADD) begin
            r_f[int'(r_k)*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            r_cy <= w_sum[CHUNK];
            r_k  <= r_k + 1'b1;
            if (w_last) begin
                r_carry <= w_sum[CHUNK];
            end
        end
    end

    assign F     = r_f;
    assign Carry = r_carry;

endmodule

// File: tb/tb_multi_cycle_adder.sv
`timescale 1ns/1ps
// Directed bench for multi_cycle_adder: 16/4 main instance plus
// 8/8 and 8/1 instances for latency corner cases.
module tb_multi_cycle_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] F;
    logic        Carry;
    logic        busy;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    logic        Sub;
`endif

    logic       iv8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c8;
    logic       rdy_w, ov_w, cy_w, bsy_w;
    logic [7:0] f_w;
    logic       rdy_n, ov_n, cy_n, bsy_n;
    logic [7:0] f_n;

    int n_cmp = 0;
    int n_bad = 0;

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef MULTI_CYCLE_ADDER_SUB_EN
        .Sub       (Sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .Carry     (Carry),
        .busy      (busy)
    );

    multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (rdy_w),
        .A         (a8),
        .B         (b8),
        .Cin       (c8),
`ifdef MULTI_CYCLE_ADDER_SUB_EN
        .Sub       (1'b0),
`endif
        .out_valid (ov_w),
        .out_ready (1'b1),
        .F         (f_w),
        .Carry     (cy_w),
        .busy      (bsy_w)
    );

    multi_cycle_adder #(.WIDTH(8), .CHUNK(1)) u_n8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (rdy_n),
        .A         (a8),
        .B         (b8),
        .Cin       (c8),
`ifdef MULTI_CYCLE_ADDER_SUB_EN
        .Sub       (1'b0),
`endif
        .out_valid (ov_n),
        .out_ready (1'b1),
        .F         (f_n),
        .Carry     (cy_n),
        .busy      (bsy_n)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands for one edge, then scramble them
    task automatic start(input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
        @(negedge clk);
        A = a;
        B = b;
        Cin = ci;
        in_valid = 1'b1;
        chk("in_ready_pre", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = 16'hDEAD;
        B = 16'hBEEF;
        Cin = ~ci;
    endtask

    task automatic wait_done(input string tag, input logic [15:0] ef,
                             input logic ec, input int lat);
        int cnt = 0;
        int bc = 0;
        while (!out_valid && cnt < 64) begin
            if (busy) bc++;
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_lat"}, cnt, lat);
        chk({tag, "_busy"}, bc, lat);
        chk({tag, "_F"}, F, ef);
        chk({tag, "_C"}, Carry, ec);
        chk({tag, "_rdy"}, in_ready, 0);
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ov0"}, out_valid, 0);
        chk({tag, "_idle"}, in_ready, 1);
    endtask

    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       input logic [7:0] ef, input logic ec);
        int lw = -1;
        int ln = -1;
        logic [7:0] fw = 8'h55;
        logic [7:0] fn = 8'h55;
        logic cw = 1'b0;
        logic cn = 1'b0;
        @(negedge clk);
        a8 = a;
        b8 = b;
        c8 = ci;
        iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov_w && lw < 0) begin
                lw = c;
                fw = f_w;
                cw = cy_w;
            end
            if (ov_n && ln < 0) begin
                ln = c;
                fn = f_n;
                cn = cy_n;
            end
        end
        chk({tag, "_c8_lat"}, lw, 1);
        chk({tag, "_c8_F"}, fw, ef);
        chk({tag, "_c8_C"}, cw, ec);
        chk({tag, "_c1_lat"}, ln, 8);
        chk({tag, "_c1_F"}, fn, ef);
        chk({tag, "_c1_C"}, cn, ec);
        chk({tag, "_idle"}, rdy_w & rdy_n & ~bsy_w & ~bsy_n, 1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = '0;
        B = '0;
        Cin = 1'b0;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
        Sub = 1'b0;
`endif
        iv8 = 1'b0;
        a8 = '0;
        b8 = '0;
        c8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        chk("rst_ov", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_F", F, 0);
        chk("rst_C", Carry, 0);
        chk("rst_rdy8", rdy_w & rdy_n, 1);
        rst_n = 1'b1;

        start(16'h00FF, 16'h0001, 1'b0);
        wait_done("add1", 16'h0100, 1'b0, 4);
        drain("add1");
        start(16'hFFFF, 16'h0001, 1'b0);
        wait_done("wrap", 16'h0000, 1'b1, 4);
        drain("wrap");
        start(16'h1234, 16'h4321, 1'b1);
        wait_done("cin", 16'h5556, 1'b0, 4);
        drain("cin");
        start(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("max", 16'hFFFF, 1'b1, 4);
        drain("max");

        // Backpressure; in_valid held during ADD must be ignored
        out_ready = 1'b0;
        start(16'h0A0A, 16'h0505, 1'b0);
        in_valid = 1'b1;
        A = 16'h1111;
        wait_done("bp", 16'h0F0F, 1'b0, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            A = A ^ 16'h5A5A;
            B = B + 16'h0101;
            in_valid = ~in_valid;
            chk("bp_F", F, 16'h0F0F);
            chk("bp_C", Carry, 0);
            chk("bp_ov", out_valid, 1);
            chk("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        chk("bp_rel_rdy", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_rel_ov", out_valid, 0);
        chk("bp_rel_idle", in_ready, 1);
        chk("bp_rel_busy", busy, 0);

        // Reset during the second ADD cycle
        start(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_F", F, 0);
        chk("mid_rst_C", Carry, 0);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", in_ready, 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("mid_rst_noout", seen, 0);
        start(16'h0003, 16'h0004, 1'b0);
        wait_done("post_rst", 16'h0007, 1'b0, 4);
        drain("post_rst");

`ifdef MULTI_CYCLE_ADDER_SUB_EN
        Sub = 1'b1;
        start(16'h0005, 16'h0007, 1'b0);
        wait_done("sub_neg", 16'hFFFE, 1'b0, 4);
        drain("sub_neg");
        start(16'h0007, 16'h0005, 1'b1);
        wait_done("sub_pos", 16'h0002, 1'b1, 4);
        drain("sub_pos");
        Sub = 1'b0;
`endif

        op8("w8a", 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1);
        op8("w8b", 8'h3C, 8'h41, 1'b1, 8'h7E, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
